// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// PROG_LOADER_CKSUM_EN adds the CKSUM state.
package prog_loader_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int WORD_W_DEF = 19;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    DATA0,
    DATA1,
    DATA2
`ifdef PROG_LOADER_CKSUM_EN
    ,
    CKSUM
`endif
  } state_t;
endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: frame parse, memory writes, CPU hold.
// Define PROG_LOADER_CKSUM_EN to check a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] data,
  output logic              we,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int AH_W = ADDR_W - 8;
  localparam int B0_W = WORD_W - 16;

  state_t            r_state;
  state_t            w_next;
  logic [AH_W-1:0]   r_ah;
  logic [7:0]        r_ch;
  logic [15:0]       r_cnt;
  logic [B0_W-1:0]   r_b0;
  logic [7:0]        r_b1;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;
  logic              r_we;
  logic              r_done;
  logic              r_hold;
  logic              w_we_n;
  logic              w_done_n;
  logic [15:0]       w_cnt16;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        r_ck;
  logic              r_err;
  logic              w_err_n;
`endif

  assign w_cnt16 = {r_ch, in_data};
  assign w_addr  = {r_ah, in_data};
  assign w_last  = (r_cnt == 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_we_n   = 1'b0;
    w_done_n = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
    w_err_n  = 1'b0;
`endif
    if (in_valid) begin
      unique case (r_state)
        IDLE:   if (in_data == HDR_BYTE) w_next = ADDR_H;
        ADDR_H: w_next = ADDR_L;
        ADDR_L: w_next = CNT_H;
        CNT_H:  w_next = CNT_L;
        CNT_L: begin
          if (w_cnt16 == 16'd0) begin
`ifdef PROG_LOADER_CKSUM_EN
            w_next = CKSUM;
`else
            w_next   = IDLE;
            w_done_n = 1'b1;
`endif
          end else begin
            w_next = DATA0;
          end
        end
        DATA0:  w_next = DATA1;
        DATA1:  w_next = DATA2;
        DATA2: begin
          w_we_n = 1'b1;
          if (w_last) begin
`ifdef PROG_LOADER_CKSUM_EN
            w_next = CKSUM;
`else
            w_next   = IDLE;
            w_done_n = 1'b1;
`endif
          end else begin
            w_next = DATA0;
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        CKSUM: begin
          w_next = IDLE;
          if (in_data == r_ck) w_done_n = 1'b1;
          else                 w_err_n  = 1'b1;
        end
`endif
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ah   <= '0;
      r_ch   <= '0;
      r_cnt  <= '0;
      r_b0   <= '0;
      r_b1   <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      r_we   <= w_we_n;
      r_done <= w_done_n;
      if (r_we) r_addr <= r_addr + ADDR_W'(1);
      if (done | error) r_hold <= 1'b0;
      if (in_valid) begin
        unique case (r_state)
          IDLE:   if (in_data == HDR_BYTE) r_hold <= 1'b1;
          ADDR_H: r_ah <= in_data[AH_W-1:0];
          ADDR_L: r_addr <= w_addr;
          CNT_H:  r_ch <= in_data;
          CNT_L:  r_cnt <= w_cnt16;
          DATA0:  r_b0 <= in_data[B0_W-1:0];
          DATA1:  r_b1 <= in_data;
          DATA2: begin
            r_data <= {r_b0, r_b1, in_data};
            r_cnt  <= r_cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  // Running XOR covers every byte between header and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ck  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_n;
      if (in_valid) begin
        if (r_state == IDLE)       r_ck <= '0;
        else if (r_state != CKSUM) r_ck <= r_ck ^ in_data;
      end
    end
  end
  assign error = r_err;
`else
  assign error = 1'b0;
`endif

  assign in_ready = rst_n;
  assign address  = r_addr;
  assign data     = r_data;
  assign we       = r_we;
  assign done     = r_done;
  assign cpu_hold = r_hold;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader; frames built from (address, words)
// and expected writes/completions derived from the frame contents.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] address;
  logic [18:0] data;
  logic        we;
  logic        cpu_hold;
  logic        done;
  logic        error;

  prog_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .address  (address),
    .data     (data),
    .we       (we),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [13:0] a;
    logic [18:0] d;
  } ev_t;

  ev_t         q[$];
  ev_t         e;
  int          errors = 0;
  int          checks = 0;
  logic [18:0] wbuf[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event with empty scoreboard", nm);
  endtask

  // Monitor: kind 0 = write, 1 = done, 2 = error
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (we) begin
          if (q.size() == 0) unexpected("we");
          else begin
            e = q.pop_front();
            chk("we_kind", e.kind, 0);
            chk("we_addr", {18'd0, address}, {18'd0, e.a});
            chk("we_data", {13'd0, data}, {13'd0, e.d});
            chk("we_hold", {31'd0, cpu_hold}, 1);
            chk("we_no_err", {31'd0, error}, 0);
          end
        end
        if (done) begin
          if (q.size() == 0) unexpected("done");
          else begin
            e = q.pop_front();
            chk("done_kind", e.kind, 1);
            chk("done_hold", {31'd0, cpu_hold}, 1);
            chk("done_no_err", {31'd0, error}, 0);
          end
        end
        if (error) begin
          if (q.size() == 0) unexpected("error");
          else begin
            e = q.pop_front();
            chk("err_kind", e.kind, 2);
            chk("err_hold", {31'd0, cpu_hold}, 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic frame(input logic [15:0] a16, input int n,
                       input int gmax, input bit bad,
                       input bit rnd_hi, input bit lead);
    logic [7:0]  ck;
    logic [13:0] ea;
    logic [15:0] n16;
    logic [7:0]  b0;
    ev_t         x;
    n16 = 16'(n);
    ck  = 8'h00;
    for (int i = 0; i < n; i++) begin
      ea  = a16[13:0] + 14'(i);
      x.kind = 0;
      x.a    = ea;
      x.d    = wbuf[i];
      q.push_back(x);
    end
    x.kind = 1;
    x.a    = '0;
    x.d    = '0;
`ifdef PROG_LOADER_CKSUM_EN
    if (bad) x.kind = 2;
`endif
    q.push_back(x);
    if (lead) begin
      send(8'h12, $urandom_range(gmax, 0));
      send(8'h34, $urandom_range(gmax, 0));
    end
    send(8'hA5, $urandom_range(gmax, 0));
    send(a16[15:8], $urandom_range(gmax, 0)); ck ^= a16[15:8];
    send(a16[7:0], $urandom_range(gmax, 0));  ck ^= a16[7:0];
    send(n16[15:8], $urandom_range(gmax, 0)); ck ^= n16[15:8];
    send(n16[7:0], $urandom_range(gmax, 0));  ck ^= n16[7:0];
    for (int i = 0; i < n; i++) begin
      b0 = {(rnd_hi ? 5'($urandom) : 5'd0), wbuf[i][18:16]};
      send(b0, $urandom_range(gmax, 0));           ck ^= b0;
      send(wbuf[i][15:8], $urandom_range(gmax, 0)); ck ^= wbuf[i][15:8];
      send(wbuf[i][7:0], $urandom_range(gmax, 0));  ck ^= wbuf[i][7:0];
    end
`ifdef PROG_LOADER_CKSUM_EN
    send(ck ^ (bad ? 8'h01 : 8'h00), 0);
`else
    if (bad) ck = ~ck;
`endif
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk({nm, "_drain"}, q.size(), 0);
    q.delete();
    repeat (2) tick();
    chk({nm, "_hold_low"}, {31'd0, cpu_hold}, 0);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_ready"}, {31'd0, in_ready}, 0);
    chk({nm, "_we"}, {31'd0, we}, 0);
    chk({nm, "_done"}, {31'd0, done}, 0);
    chk({nm, "_err"}, {31'd0, error}, 0);
    chk({nm, "_hold"}, {31'd0, cpu_hold}, 0);
    chk({nm, "_addr"}, {18'd0, address}, 0);
    chk({nm, "_data"}, {13'd0, data}, 0);
  endtask

  initial begin
    repeat (3) tick();
    reset_checks("rst");
    rst_n = 1'b1;
    tick();
    chk("ready_run", {31'd0, in_ready}, 1);

    wbuf[0] = 19'h7FFFF;
    frame(16'h0010, 1, 0, 1'b0, 1'b0, 1'b0);
    drain("single");

    wbuf[0] = 19'h00001;
    wbuf[1] = 19'h00002;
    frame(16'h3FFF, 2, 0, 1'b0, 1'b0, 1'b0);
    drain("wrap");

    frame(16'h0000, 0, 0, 1'b0, 1'b0, 1'b0);
    drain("cnt0");

`ifdef PROG_LOADER_CKSUM_EN
    for (int i = 0; i < 3; i++) wbuf[i] = 19'($urandom);
    frame(16'(16'h0100 + $urandom_range(255, 0)), 3, 1, 1'b1, 1'b1, 1'b0);
    drain("bad_ck");
`endif

    for (int i = 0; i < 2; i++) wbuf[i] = 19'($urandom);
    frame(16'h1234, 2, 3, 1'b0, 1'b1, 1'b1);
    drain("lead_gap");

    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h20, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h05, 0);
    send(8'h55, 0);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(8'h7E, 0);
    wbuf[0] = 19'h2ABCD;
    frame(16'h0020, 1, 1, 1'b0, 1'b1, 1'b0);
    drain("after_rst");

    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(5, 1);
      for (int i = 0; i < n; i++) wbuf[i] = 19'($urandom);
      frame(16'($urandom), n, 2, 1'b0, 1'b1, $urandom_range(1, 0) == 1);
      drain("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
